// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between requesters A and B
// One operation in flight: IDLE grants, EXEC drives the ALU for one cycle, RESP holds the result.
module alu_arbiter #(
  parameter logic INIT_PTR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic        b_valid,
  output logic        a_ready,
  output logic        b_ready,
  input  logic [31:0] a_src1,
  input  logic [31:0] a_src2,
  input  logic [31:0] b_src1,
  input  logic [31:0] b_src2,
  input  logic [4:0]  a_shamt,
  input  logic [4:0]  b_shamt,
  input  logic [5:0]  a_funct,
  input  logic [5:0]  b_funct,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_funct,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        a_rvalid,
  output logic        b_rvalid,
  input  logic        a_rready,
  input  logic        b_rready,
  output logic [31:0] a_rdata,
  output logic [31:0] b_rdata,
  output logic        a_rzero,
  output logic        b_rzero,
  output logic        a_rerr,
  output logic        b_rerr
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_AND  = 6'b010001;
  localparam logic [5:0] F_SLL  = 6'b100001;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [5:0]  funct_q, funct_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rzero_q, rzero_d;
  logic        rerr_q, rerr_d;
  logic        pick_b;
  logic        legal;
  logic        resp_a;
  logic        resp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= INIT_PTR;
      gnt_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      shamt_q <= '0;
      funct_q <= '0;
      rdata_q <= '0;
      rzero_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      shamt_q <= shamt_d;
      funct_q <= funct_d;
      rdata_q <= rdata_d;
      rzero_q <= rzero_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    shamt_d   = shamt_q;
    funct_d   = funct_q;
    rdata_d   = rdata_q;
    rzero_d   = rzero_q;
    rerr_d    = rerr_q;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    alu_src1  = '0;
    alu_src2  = '0;
    alu_shamt = '0;
    alu_funct = '0;
    pick_b    = b_valid && (!a_valid || ptr_q);
    legal     = (funct_q == F_ADDU) || (funct_q == F_SUBU) ||
                (funct_q == F_AND)  || (funct_q == F_SLL);

    case (state_q)
      IDLE: begin
        // rst_n gate keeps ready low while reset is held, even though state is already IDLE
        if (rst_n && (a_valid || b_valid)) begin
          a_ready = !pick_b;
          b_ready = pick_b;
          gnt_d   = pick_b;
          ptr_d   = !pick_b;
          src1_d  = pick_b ? b_src1  : a_src1;
          src2_d  = pick_b ? b_src2  : a_src2;
          shamt_d = pick_b ? b_shamt : a_shamt;
          funct_d = pick_b ? b_funct : a_funct;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (legal) begin
          alu_src1  = src1_q;
          alu_src2  = src2_q;
          alu_shamt = shamt_q;
          alu_funct = funct_q;
          rdata_d   = alu_result;
          rzero_d   = alu_zero;
          rerr_d    = 1'b0;
        end else begin
          rdata_d = '0;
          rzero_d = 1'b0;
          rerr_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (gnt_q ? b_rready : a_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_a   = (state_q == RESP) && !gnt_q;
    resp_b   = (state_q == RESP) && gnt_q;
    a_rvalid = resp_a;
    b_rvalid = resp_b;
    a_rdata  = resp_a ? rdata_q : '0;
    b_rdata  = resp_b ? rdata_q : '0;
    a_rzero  = resp_a & rzero_q;
    b_rzero  = resp_b & rzero_q;
    a_rerr   = resp_a & rerr_q;
    b_rerr   = resp_b & rerr_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with scoreboard of expected responses
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_src1, a_src2, b_src1, b_src2;
  logic [4:0]  a_shamt, b_shamt;
  logic [5:0]  a_funct, b_funct;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        alu_zero;
  logic        a_rvalid, b_rvalid, a_rready, b_rready;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rzero, b_rzero, a_rerr, b_rerr;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_src1(a_src1), .a_src2(a_src2), .b_src1(b_src1), .b_src2(b_src2),
    .a_shamt(a_shamt), .b_shamt(b_shamt), .a_funct(a_funct), .b_funct(b_funct),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .a_rready(a_rready), .b_rready(b_rready),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_rzero(a_rzero), .b_rzero(b_rzero),
    .a_rerr(a_rerr), .b_rerr(b_rerr)
  );

  // Shared combinational ALU
  always_comb begin
    case (alu_funct)
      6'b001001: alu_result = alu_src1 + alu_src2;
      6'b001010: alu_result = alu_src1 - alu_src2;
      6'b010001: alu_result = alu_src1 & alu_src2;
      6'b100001: alu_result = alu_src1 << alu_shamt;
      default:   alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  function automatic exp_t model(input logic who, input logic [5:0] f,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [4:0] sh);
    exp_t e;
    e.who = who;
    e.err = 1'b0;
    case (f)
      6'b001001: e.data = s1 + s2;
      6'b001010: e.data = s1 - s2;
      6'b010001: e.data = s1 & s2;
      6'b100001: e.data = s1 << sh;
      default: begin e.data = 32'h0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.data == 32'h0);
    return e;
  endfunction

  function automatic logic [5:0] legal_funct(input int k);
    case (k % 4)
      0: return 6'b001001;
      1: return 6'b001010;
      2: return 6'b010001;
      default: return 6'b100001;
    endcase
  endfunction

  task automatic set_a(input logic [5:0] f, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh);
    a_funct = f; a_src1 = s1; a_src2 = s2; a_shamt = sh;
  endtask

  task automatic set_b(input logic [5:0] f, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] sh);
    b_funct = f; b_src1 = s1; b_src2 = s2; b_shamt = sh;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_rready = 1'b1; b_rready = 1'b1;
    set_a(6'b001001, 32'd1, 32'd2, 5'd0);
    set_b(6'b001010, 32'd3, 32'd1, 5'd0);
    @(negedge clk); #1;
    tests++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata, a_rzero, b_rzero, a_rerr, b_rerr,
         alu_src1, alu_src2, alu_shamt, alu_funct} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: a_ready=%b b_ready=%b a_rvalid=%b b_rvalid=%b alu_funct=%h, required all 0",
               a_ready, b_ready, a_rvalid, b_rvalid, alu_funct);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    e = '0;
    tests++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0) begin
      fails++;
      $display("FAIL idle_after_reset: ready/rvalid=%b required 0000", {a_ready, b_ready, a_rvalid, b_rvalid});
    end
    exp_q.delete();
  endtask

  task automatic test_single_a;
    exp_t e;
    @(negedge clk);
    set_a(6'b001001, 32'd5, 32'd7, 5'd0);
    a_valid = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_a_grant: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
    end
    exp_q.push_back(model(1'b0, a_funct, a_src1, a_src2, a_shamt));
    @(negedge clk); a_valid = 1'b0; #1;
    tests++;
    if (alu_funct !== 6'b001001 || alu_src1 !== 32'd5 || alu_src2 !== 32'd7 || a_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_a_exec: alu_funct=%b src1=%0d src2=%0d rvalid=%b required 001001 5 7 0",
               alu_funct, alu_src1, alu_src2, a_rvalid);
    end
    @(negedge clk); #1;
    tests++;
    if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL single_a_rvalid: a_rvalid=%b b_rvalid=%b pending=%0d required 1 0 1", a_rvalid, b_rvalid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (a_rdata !== e.data || a_rzero !== e.zero || a_rerr !== e.err) begin
        fails++;
        $display("FAIL single_a_data: rdata=%0d rzero=%b rerr=%b required %0d %b %b",
                 a_rdata, a_rzero, a_rerr, e.data, e.zero, e.err);
      end
    end
    @(negedge clk); #1;
    tests++;
    if (a_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_a_release: a_rvalid=%b required 0", a_rvalid);
    end
  endtask

  task automatic test_b_ops;
    exp_t        e;
    logic [5:0]  fs  [3] = '{6'b001010, 6'b100001, 6'b010001};
    logic [31:0] s1s [3] = '{32'd9, 32'd1, 32'hF0F0_1234};
    logic [31:0] s2s [3] = '{32'd9, 32'hDEAD_BEEF, 32'h0FF0_FFFF};
    logic [4:0]  shs [3] = '{5'd3, 5'd31, 5'd0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_b(fs[k], s1s[k], s2s[k], shs[k]);
      b_valid = 1'b1;
      #1;
      tests++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
        fails++;
        $display("FAIL b_op%0d_grant: b_ready=%b a_ready=%b required 1 0", k, b_ready, a_ready);
      end
      exp_q.push_back(model(1'b1, b_funct, b_src1, b_src2, b_shamt));
      @(negedge clk); b_valid = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0 || exp_q.size() == 0) begin
        fails++;
        $display("FAIL b_op%0d_rvalid: b_rvalid=%b a_rvalid=%b required 1 0", k, b_rvalid, a_rvalid);
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (b_rdata !== e.data || b_rzero !== e.zero || b_rerr !== e.err || a_rdata !== 32'h0) begin
          fails++;
          $display("FAIL b_op%0d_data: rdata=%h rzero=%b rerr=%b a_rdata=%h required %h %b %b 0",
                   k, b_rdata, b_rzero, b_rerr, a_rdata, e.data, e.zero, e.err);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    exp_t e;
    @(negedge clk);
    set_a(6'b000111, 32'd11, 32'd22, 5'd4);
    a_valid = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_grant: a_ready=%b required 1", a_ready);
    end
    exp_q.push_back(model(1'b0, a_funct, a_src1, a_src2, a_shamt));
    @(negedge clk); a_valid = 1'b0; #1;
    tests++;
    if (alu_funct !== 6'b0 || alu_src1 !== 32'h0 || alu_src2 !== 32'h0 || alu_shamt !== 5'h0) begin
      fails++;
      $display("FAIL illegal_alu_idle: alu_funct=%b src1=%h src2=%h shamt=%0d required all 0",
               alu_funct, alu_src1, alu_src2, alu_shamt);
    end
    @(negedge clk); #1;
    tests++;
    if (a_rvalid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL illegal_rvalid: a_rvalid=%b required 1", a_rvalid);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (a_rerr !== e.err || a_rdata !== e.data || a_rzero !== e.zero) begin
        fails++;
        $display("FAIL illegal_payload: rerr=%b rdata=%h rzero=%b required %b %h %b",
                 a_rerr, a_rdata, a_rzero, e.err, e.data, e.zero);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   ngrants = 0;
    logic last = 1'b0;
    logic who;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_a(legal_funct(0), $urandom, $urandom, 5'($urandom_range(31)));
    set_b(legal_funct(1), $urandom, $urandom, 5'($urandom_range(31)));
    a_valid = 1'b1; b_valid = 1'b1;
    for (int c = 0; c < 40 && ngrants < 8; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (a_rvalid || b_rvalid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected_resp: a_rvalid=%b b_rvalid=%b with empty scoreboard", a_rvalid, b_rvalid);
        end else begin
          e = exp_q.pop_front();
          if ({a_rvalid, b_rvalid} !== (e.who ? 2'b01 : 2'b10) ||
              (e.who ? b_rdata : a_rdata) !== e.data || (e.who ? b_rzero : a_rzero) !== e.zero) begin
            fails++;
            $display("FAIL b2b_resp: rvalid_ab=%b%b rdata_a=%h rdata_b=%h required who=%b data=%h zero=%b",
                     a_rvalid, b_rvalid, a_rdata, b_rdata, e.who, e.data, e.zero);
          end
        end
      end
      if (a_ready || b_ready) begin
        who = b_ready;
        tests++;
        if ((a_ready && b_ready) || (ngrants == 0 && who !== 1'b0) || (ngrants != 0 && who === last)) begin
          fails++;
          $display("FAIL b2b_grant%0d: a_ready=%b b_ready=%b last=%b required alternating starting with A",
                   ngrants, a_ready, b_ready, last);
        end
        if (who) exp_q.push_back(model(1'b1, b_funct, b_src1, b_src2, b_shamt));
        else     exp_q.push_back(model(1'b0, a_funct, a_src1, a_src2, a_shamt));
        last = who;
        ngrants++;
        @(negedge clk);
        if (who) set_b(legal_funct(ngrants), $urandom, $urandom, 5'($urandom_range(31)));
        else     set_a(legal_funct(ngrants + 2), $urandom, $urandom, 5'($urandom_range(31)));
        #1;
      end
    end
    tests++;
    if (ngrants != 8) begin
      fails++;
      $display("FAIL b2b_grant_count: grants=%0d required 8 within budget", ngrants);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if ((a_rvalid || b_rvalid) && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        if ((e.who ? b_rdata : a_rdata) !== e.data || (e.who ? b_rvalid : a_rvalid) !== 1'b1) begin
          fails++;
          $display("FAIL b2b_drain: rdata_a=%h rdata_b=%h required who=%b data=%h", a_rdata, b_rdata, e.who, e.data);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_scoreboard_empty: pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    exp_t        e;
    logic [31:0] held;
    @(negedge clk);
    set_a(6'b001001, 32'd3, 32'd4, 5'd0);
    a_valid = 1'b1; a_rready = 1'b0;
    #1;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_grant_a: a_ready=%b required 1", a_ready);
    end
    exp_q.push_back(model(1'b0, a_funct, a_src1, a_src2, a_shamt));
    @(negedge clk);
    a_valid = 1'b0;
    set_b(6'b001001, 32'd1, 32'd1, 5'd0);
    b_valid = 1'b1;
    @(negedge clk); #1;
    held = a_rdata;
    tests++;
    if (a_rvalid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL bp_rvalid: a_rvalid=%b required 1", a_rvalid);
    end else begin
      e = exp_q.pop_front();
      if (a_rdata !== e.data) begin
        fails++;
        $display("FAIL bp_data: rdata=%0d required %0d", a_rdata, e.data);
      end
      held = e.data;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      tests++;
      if (a_rvalid !== 1'b1 || a_rdata !== held || b_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: a_rvalid=%b rdata=%0d b_ready=%b required 1 %0d 0", c, a_rvalid, a_rdata, b_ready, held);
      end
    end
    @(negedge clk); a_rready = 1'b1; #1;
    tests++;
    if (a_rvalid !== 1'b1 || b_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: a_rvalid=%b b_ready=%b required 1 0", a_rvalid, b_ready);
    end
    @(negedge clk); #1;
    tests++;
    if (b_ready !== 1'b1 || a_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_grant: b_ready=%b a_rvalid=%b required 1 0", b_ready, a_rvalid);
    end
    exp_q.push_back(model(1'b1, b_funct, b_src1, b_src2, b_shamt));
    @(negedge clk); b_valid = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (b_rvalid !== 1'b1 || exp_q.size() == 0) begin
      fails++;
      $display("FAIL bp_b_resp: b_rvalid=%b required 1", b_rvalid);
    end else begin
      e = exp_q.pop_front();
      if (b_rdata !== e.data) begin
        fails++;
        $display("FAIL bp_b_data: rdata=%0d required %0d", b_rdata, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec;
    exp_t e;
    @(negedge clk);
    set_a(6'b010001, 32'hFFFF_0000, 32'h00FF_FF00, 5'd0);
    a_valid = 1'b1;
    #1;
    tests++;
    if (a_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_grant: a_ready=%b required 1", a_ready);
    end
    @(negedge clk); a_valid = 1'b0; #1;
    tests++;
    if (alu_funct !== 6'b010001) begin
      fails++;
      $display("FAIL rst_mid_exec: alu_funct=%b required 010001", alu_funct);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata, a_rerr, b_rerr, alu_src1, alu_src2, alu_funct} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: alu_funct=%b alu_src1=%h a_rvalid=%b required all 0", alu_funct, alu_src1, a_rvalid);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    set_b(6'b001010, 32'd10, 32'd4, 5'd0);
    @(negedge clk); #1;
    tests++;
    if ({a_ready, b_ready, a_rvalid, b_rvalid} !== 4'b0) begin
      fails++;
      $display("FAIL rst_hold: ready/rvalid=%b required 0000", {a_ready, b_ready, a_rvalid, b_rvalid});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || a_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_init_ptr: a_ready=%b b_ready=%b a_rvalid=%b required 1 0 0", a_ready, b_ready, a_rvalid);
    end
    exp_q.push_back(model(1'b0, a_funct, a_src1, a_src2, a_shamt));
    @(negedge clk); a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (a_rvalid !== 1'b1 || exp_q.size() != 1) begin
      fails++;
      $display("FAIL rst_post_resp: a_rvalid=%b pending=%0d required 1 1", a_rvalid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (a_rdata !== e.data || a_rzero !== e.zero) begin
        fails++;
        $display("FAIL rst_post_data: rdata=%h rzero=%b required %h %b", a_rdata, a_rzero, e.data, e.zero);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_rready = 1'b1; b_rready = 1'b1;
    set_a(6'b0, 32'h0, 32'h0, 5'd0);
    set_b(6'b0, 32'h0, 32'h0, 5'd0);
    test_reset;
    test_single_a;
    test_b_ops;
    test_illegal;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_exec;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter INIT_PTR, default 0, meaning the requester given priority first after reset (0 = A, 1 = B).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 The block SHALL have ports a_valid / b_valid, input, 1 bit each, request present.
REQ-005 The block SHALL have ports a_ready / b_ready, output, 1 bit each, request accepted this cycle.
REQ-006 The block SHALL have ports a_src1/a_src2/b_src1/b_src2 (input, 32), a_shamt/b_shamt (input, 5) and a_funct/b_funct (input, 6), the request operands.
REQ-007 The block SHALL have ports alu_src1, alu_src2 (output, 32), alu_shamt (output, 5) and alu_funct (output, 6), driving the shared ALU.
REQ-008 The block SHALL have ports alu_result (input, 32) and alu_zero (input, 1), the combinational ALU outputs.
REQ-009 The block SHALL have ports a_rvalid / b_rvalid (output, 1) and a_rready / b_rready (input, 1), the response handshake.
REQ-010 The block SHALL have ports a_rdata / b_rdata (output, 32), a_rzero / b_rzero (output, 1) and a_rerr / b_rerr (output, 1), the response payload.

Function
REQ-011 FSM states SHALL be IDLE, EXEC, RESP; exactly one ALU operation in flight.
REQ-012 IDLE: a grant SHALL be issued when at least one valid is high; x_ready=1 for the granted requester only, in the same cycle; operands registered; next state EXEC.
REQ-013 Arbitration SHALL be round-robin: if both valid, the requester not served last wins; priority pointer flips to the other requester after each grant.
REQ-014 With a single valid requester, that requester SHALL be granted regardless of the pointer.
REQ-015 Legal funct codes SHALL be 6'b001001 addu, 6'b001010 subu, 6'b010001 and, 6'b100001 sll.
REQ-016 EXEC, legal funct: alu_* outputs SHALL present the registered operands for exactly one cycle; alu_result/alu_zero captured at the end of that cycle; next state RESP.
REQ-017 EXEC, illegal funct: the ALU SHALL NOT be driven (alu_funct = 6'b000000); captured rdata=0, rzero=0, rerr=1; next state RESP.
REQ-018 Outside EXEC, alu_src1/alu_src2/alu_shamt/alu_funct SHALL be 0.
REQ-019 RESP: only the granted requester's x_rvalid=1, with rdata/rzero/rerr stable until x_rready=1; other requester's response outputs 0.
REQ-020 On the x_rvalid & x_rready cycle the FSM SHALL return to IDLE; a new grant occurs at the earliest the following cycle.
REQ-021 Latency SHALL be 2 cycles from the grant edge to rvalid; throughput is at best one operation per 3 cycles.
REQ-022 Requests arriving during EXEC/RESP SHALL be held by the requester (ready=0); no request is dropped or queued internally.
REQ-023 The sll result SHALL be src1 << shamt with src2 ignored; add/sub wrap modulo 2^32 with no overflow flag.

Reset
REQ-024 rst_n=0 SHALL asynchronously force IDLE, pointer=INIT_PTR, and all outputs to 0 (ready, rvalid, rdata, rzero, rerr, alu_*).
REQ-025 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response is issued after release.
REQ-026 The first grant after release SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-027 A only: addu 5+7 -> a_ready at cycle 0; alu_funct=001001 at cycle 1; a_rvalid, a_rdata=12, a_rzero=0 at cycle 2.
REQ-028 A and B valid every cycle, INIT_PTR=0 -> grants alternate A,B,A,B; neither requester is ever granted twice in a row.
REQ-029 B: subu 9-9 -> b_rdata=0, b_rzero=1; sll src1=1, shamt=31 -> rdata=32'h80000000.
REQ-030 A: funct=6'b000111 -> alu_funct stays 0; a_rerr=1, a_rdata=0 at cycle 2.
REQ-031 rvalid held with rready=0 for 5 cycles -> payload stable and no new grant; grant follows the cycle after rready=1.
REQ-032 rst_n low during EXEC -> all outputs 0 immediately; no rvalid after release; the next grant goes to INIT_PTR's requester when both are valid.
